mux8_scan_ctrl: RTL

- Sequencer that sits directly around the 8-to-1 MUX stage.
- Drives the MUX select lines S2..S0 through channels 0..7 in order and samples the MUX output Y on each channel.
- Packs the eight samples into one parallel byte and signals completion with a one-cycle done pulse.
- Turns the combinational MUX into a framed 8-bit input scanner for downstream logic.

---
 rtl/mux8_scan_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mux8_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux8_scan_ctrl
//
// Sequencer wrapped around an external 8-to-1 MUX. It steps the MUX select
// lines through channels 0..7, samples the MUX output Y once per channel after
// a programmable settle time, and presents the eight samples as one parallel
// byte together with a one-cycle done pulse. The result is a framed 8-bit
// input scanner built from a combinational MUX.
//
// Parameters
//   SETTLE    wait cycles after each select change before Y is sampled
//             (0..15; 0 samples in the first cycle after the change)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   start     request one scan frame (only looked at while idle)
//   cont      continuous mode (only looked at in the done cycle)
//   Y         output of the external 8-to-1 MUX
//   S2,S1,S0  MUX select, MSB..LSB, always straight from a register
//   busy      high while a frame is in progress (WAIT, CAPTURE, DONE)
//   done      one-cycle pulse while data_out holds a freshly completed frame
//   data_out  last completed frame; bit k = Y sampled while select = k
// -----------------------------------------------------------------------------
module mux8_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       Y,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  // A new channel begins in WAIT unless there is nothing to wait for.
  localparam state_t FIRST_ST = (SETTLE == 0) ? ST_CAPTURE : ST_WAIT;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] sel;
  logic [3:0] cnt;
  logic [6:0] shift;

  logic launch;
  logic last_ch;

  // A frame launches from IDLE on start, or back-to-back from DONE in
  // continuous mode; both paths set up the channel-0 settle identically.
  assign launch  = ((state == ST_IDLE) && start) ||
                   ((state == ST_DONE) && cont);
  assign last_ch = (sel == 3'd7);

  // ---- state register ------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = FIRST_ST;
        end
      end
      ST_WAIT: begin
        // cnt counts down the remaining settle cycles; leave on the last one.
        if (cnt <= 4'd1) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (last_ch) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = FIRST_ST;
        end
      end
      ST_DONE: begin
        if (cont) begin
          state_nxt = FIRST_ST;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- outputs decoded from the state register -----------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_IDLE:    busy = 1'b0;
      ST_WAIT:    busy = 1'b1;
      ST_CAPTURE: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // ---- select counter and settle counter -----------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= 3'd0;
      cnt <= 4'd0;
    end else if (launch) begin
      sel <= 3'd0;
      cnt <= SETTLE_CNT;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
        end
        ST_CAPTURE: begin
          // After channel 7 the select parks at 0 for DONE and IDLE.
          if (last_ch) begin
            sel <= 3'd0;
          end else begin
            sel <= sel + 3'd1;
            cnt <= SETTLE_CNT;
          end
        end
        default: begin
          sel <= sel;
          cnt <= cnt;
        end
      endcase
    end
  end

  // ---- sample capture and frame output --------------------------------------
  // Channels 0..6 are held in shift; channel 7 goes straight into data_out
  // together with them, so data_out only moves on the final capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= 7'd0;
      data_out <= 8'h00;
    end else if (state == ST_CAPTURE) begin
      if (last_ch) begin
        data_out <= {Y, shift};
      end else begin
        for (int k = 0; k < 7; k++) begin
          if (sel == 3'(k)) begin
            shift[k] <= Y;
          end
        end
      end
    end
  end

  assign S2 = sel[2];
  assign S1 = sel[1];
  assign S0 = sel[0];

endmodule
